pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch-stage controller directly upstream of the PC+4 Adder.
- Holds the architectural PC and drives it to the Adder's src1_i; takes the Adder's sum_o back as the sequential next PC.
- Runs a req/ack handshake to instruction memory and presents each fetched instruction to decode with a valid/ready handshake.
- Supports branch/jump redirect and a memory-timeout halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT_CYC, 16, REQ cycles without ack before halting; 0 disables the timeout; legal range 0..65535.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  reset; synchronous, active-high.
pc_o  output  32  current fetch PC; to Adder src1_i.
pc_plus4_i  input  32  Adder sum_o (pc_o + 4).
imem_req_o  output  1  fetch request to instruction memory.
imem_addr_o  output  32  fetch address; always equals pc_o.
imem_ack_i  input  1  memory returns data this cycle.
imem_data_i  input  32  instruction word; valid when imem_ack_i=1.
instr_o  output  32  registered instruction to decode.
instr_valid_o  output  1  instr_o holds a valid instruction.
instr_ready_i  input  1  decode accepts instr_o.
redirect_i  input  1  branch/jump taken; load redirect_pc_i.
redirect_pc_i  input  32  redirect target.
timeout_o  output  1  sticky; memory ack timeout occurred.
fault_o  output  1  sticky misaligned-redirect fault; tied 0 unless PC_ALIGN_CHECK_EN.

Behaviour:
- Reset (rst_i=1 at edge):
  - pc_o=RESET_PC, state=IDLE, instr_o=0, instr_valid_o=0.
  - timeout_o=0, fault_o=0, wait counter=0.
  - Reset overrides every other input in any state, including mid-handshake; an ack arriving in the reset cycle is discarded.
- States: IDLE, REQ, HOLD, HALT. imem_req_o is high only in REQ (combinational from state).
- IDLE -> REQ unconditionally on the next edge. The first request is asserted in the 2nd cycle after rst_i deasserts.
- REQ:
  - imem_addr_o=pc_o.
  - On imem_ack_i=1: instr_o<=imem_data_i, instr_valid_o<=1, counter<=0, -> HOLD. Ack-to-valid latency is 1 cycle.
  - Otherwise counter increments.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 with no ack this cycle: timeout_o<=1, -> HALT. Example: TIMEOUT_CYC=16 halts after 16 REQ cycles with no ack.
- HOLD:
  - instr_o and instr_valid_o are stable.
  - On instr_ready_i=1: pc_o<=pc_plus4_i, instr_valid_o<=0, -> REQ. The next request appears the cycle after acceptance.
- HALT: imem_req_o=0, instr_valid_o=0, pc_o frozen. Exits only via reset; redirect_i is ignored.
- Redirect (redirect_i=1 in IDLE, REQ or HOLD) has priority over ack, ready and timeout:
  - pc_o<=redirect_pc_i, instr_valid_o<=0, counter<=0, -> REQ.
  - Ack in the same cycle: data discarded, instr_o unchanged.
  - Ready in the same cycle: pc_plus4_i ignored.
  - Timeout in the same cycle: no timeout, timeout_o unchanged.
- Wrap-around: pc_plus4_i is taken verbatim. pc_o=32'hFFFF_FFFC followed by acceptance gives pc_o=0; no flag is raised.
- instr_valid_o, once high, never drops without instr_ready_i, redirect_i or rst_i.
- Memory is assumed to drive imem_ack_i only while imem_req_o=1. An ack outside REQ is ignored.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 sets fault_o<=1 (sticky), leaves pc_o unchanged, clears instr_valid_o, -> HALT.
  - An aligned redirect behaves as normal.
  - Reset clears fault_o.
- Undefined: redirect_pc_i is loaded verbatim, including low bits; fault_o is constant 0.

Test Plan:
- Reset/first fetch: RESET_PC=0, rst_i high 2 cycles then low; ack 1 cycle after req with data 32'h2002_0005 -> req high from 2nd post-reset cycle with addr 0; instr_o=32'h2002_0005 and instr_valid_o=1 the cycle after ack.
- Sequential stream with backpressure: Adder connected, ack immediate, instr_ready_i held low 3 cycles per instruction -> addresses 0,4,8,C in order; instr_o held stable while not ready; no instruction dropped or duplicated.
- Redirect collisions: redirect to 32'h0000_0100 in the same cycle as ack -> ack data discarded, next req addr 0x100. Redirect in HOLD with instr_ready_i=1 -> pc_o=0x100, not pc+4.
- Timeout: TIMEOUT_CYC=4, never ack -> timeout_o=1 after the 4th REQ cycle; req low thereafter; redirect ignored; rst_i clears to IDLE with pc_o=RESET_PC.
- Wrap: redirect to 32'hFFFF_FFFC, ack, ready -> next req addr 32'h0000_0000.
- PC_ALIGN_CHECK_EN defined: redirect to 32'h0000_0102 -> fault_o=1, state HALT, pc_o unchanged. Macro undefined: same stimulus -> req addr 32'h0000_0102, fault_o=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, runs the imem req/ack handshake and hands instructions to
// decode. Optional misaligned-redirect fault is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] pc_o,
   input  logic [31:0] pc_plus4_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        timeout_o,
   output logic        fault_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   localparam bit        TIMEOUT_EN = (TIMEOUT_CYC != 0);
   // Last wait-count value before halting; unused when the timeout is disabled.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
`ifdef PC_ALIGN_CHECK_EN
   logic        fault_q, fault_d;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
`ifdef PC_ALIGN_CHECK_EN
      fault_d   = fault_q;
`endif
      // Redirect outranks ack, ready and timeout in every live state.
      if (redirect_i && (state_q != ST_HALT)) begin
         valid_d = 1'b0;
         cnt_d   = '0;
`ifdef PC_ALIGN_CHECK_EN
         if (redirect_pc_i[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
         end else
`endif
         begin
            pc_d    = redirect_pc_i;
            state_d = ST_REQ;
         end
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
               if (imem_ack_i) begin
                  instr_d = imem_data_i;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                  timeout_d = 1'b1;
                  state_d   = ST_HALT;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_HOLD: begin
               if (instr_ready_i) begin
                  pc_d    = pc_plus4_i;
                  valid_d = 1'b0;
                  state_d = ST_REQ;
               end
            end
            default: valid_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
   assign fault_o = fault_q;
`else
   assign fault_o = 1'b0;
`endif

   assign pc_o          = pc_q;
   assign imem_addr_o   = pc_q;
   assign imem_req_o    = (state_q == ST_REQ);
   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: a transaction-level model predicts PC/req/flags each cycle
// and queues every captured instruction; a monitor pops the queue when decode sees it presented.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned TO     = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] pc_o, pc_plus4_i, imem_addr_o, imem_data_i, instr_o, redirect_pc_i;
   logic        imem_req_o, imem_ack_i, instr_valid_o, instr_ready_i, redirect_i;
   logic        timeout_o, fault_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // The PC+4 adder sitting downstream.
   assign pc_plus4_i = pc_o + 32'd4;

   pc_fetch_ctrl #(
      .RESET_PC   (RST_PC),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .pc_o         (pc_o),
      .pc_plus4_i   (pc_plus4_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_data_i  (imem_data_i),
      .instr_o      (instr_o),
      .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .timeout_o    (timeout_o),
      .fault_o      (fault_o)
   );

   // Reference model: fetch stream as a sequence of transactions, not states.
   logic [31:0] m_pc;
   bit          m_started, m_have, m_halted, m_timeout, m_fault;
   int unsigned m_wait;
   logic [31:0] exp_q[$];

   function automatic bit exp_req();
      return m_started && !m_have && !m_halted;
   endfunction

   task automatic reset_model();
      m_pc = RST_PC; m_started = 0; m_have = 0; m_halted = 0;
      m_timeout = 0; m_fault = 0; m_wait = 0;
   endtask

   task automatic model_update(input bit r, input bit rd, input logic [31:0] rpc, input bit ak,
                               input logic [31:0] dat, input bit rdy);
      bit bad;
      bad = 0;
`ifdef PC_ALIGN_CHECK_EN
      bad = (rpc[1:0] != 2'b00);
`endif
      if (r) reset_model();
      else if (m_halted) begin
      end else if (rd) begin
         m_have = 0; m_wait = 0; m_started = 1;
         if (bad) begin m_fault = 1; m_halted = 1; end
         else m_pc = rpc;
      end else if (!m_started) m_started = 1;
      else if (!m_have) begin
         if (ak) begin exp_q.push_back(dat); m_have = 1; m_wait = 0; end
         else begin
            m_wait++;
            if (TO != 0 && m_wait == TO) begin m_timeout = 1; m_halted = 1; end
         end
      end else if (rdy) begin
         m_pc = m_pc + 32'd4; m_have = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge: check current outputs, drive inputs for the next edge, advance model.
   task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit ak,
                       input logic [31:0] dat, input bit rdy);
      chk("pc", pc_o, m_pc);
      chk("imem_addr", imem_addr_o, m_pc);
      chk("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req()});
      chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, m_have && !m_halted});
      chk("timeout", {31'b0, timeout_o}, {31'b0, m_timeout});
      chk("fault", {31'b0, fault_o}, {31'b0, m_fault});
      rst_i = r; redirect_i = rd; redirect_pc_i = rpc; imem_ack_i = ak;
      imem_data_i = dat; instr_ready_i = rdy;
      model_update(r, rd, rpc, ak, dat, rdy);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 32'h0, 0, 32'h0, rdy);
   endtask

   task automatic wait_req();
      for (int k = 0; k < 8 && !exp_req(); k++) idle(1);
   endtask

   task automatic fetch(input logic [31:0] d, input int hold);
      wait_req();
      step(0, 0, 32'h0, 1, d, 0);
      repeat (hold) idle(0);
      idle(1);
   endtask

   // Monitor: each newly presented instruction must match the queue head and stay stable.
   logic [31:0] cur = '0;
   bit          prev_v = 0;
   always @(negedge clk) begin
      if (instr_valid_o === 1'b1 && !prev_v) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL instr_present: got %h expected no instruction", instr_o);
         end else begin
            cur = exp_q.pop_front();
            if (instr_o !== cur) begin
               errors++;
               $display("FAIL instr_data: got %h expected %h at %0t", instr_o, cur, $time);
            end
         end
      end else if (instr_valid_o === 1'b1) begin
         checks++;
         if (instr_o !== cur) begin
            errors++;
            $display("FAIL instr_hold: got %h expected %h at %0t", instr_o, cur, $time);
         end
      end
      prev_v = (instr_valid_o === 1'b1);
   end

   initial begin
      logic [31:0] tgt;
      bit          ak, rd;
      rst_i = 1; redirect_i = 0; redirect_pc_i = '0; imem_ack_i = 0; imem_data_i = '0;
      instr_ready_i = 0;
      reset_model();
      @(posedge clk);
      @(negedge clk);
      step(1, 0, 32'h0, 1, 32'h1111_1111, 0);  // ack during reset must be discarded

      // First fetch: idle cycle, first req cycle, ack one cycle later.
      idle(0);
      idle(0);
      step(0, 0, 32'h0, 1, 32'h2002_0005, 0);
      idle(0);
      idle(1);

      // Sequential stream with backpressure.
      for (int i = 0; i < 4; i++) fetch($urandom, 3);

      // Redirect colliding with ack, then with ready in HOLD.
      wait_req();
      step(0, 1, 32'h0000_0100, 1, 32'hDEAD_BEEF, 0);
      fetch(32'hA5A5_0001, 1);
      wait_req();
      step(0, 0, 32'h0, 1, 32'hA5A5_0002, 0);
      step(0, 1, 32'h0000_0100, 0, 32'h0, 1);
      fetch(32'hA5A5_0003, 0);

      // PC wrap-around.
      wait_req();
      step(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
      fetch(32'hA5A5_0004, 0);
      fetch(32'hA5A5_0005, 0);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            step(1, 0, 32'h0, 0, 32'h0, 0);
            continue;
         end
         rd  = ($urandom_range(0, 19) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         if (exp_req()) ak = (m_wait >= 2) || ($urandom_range(0, 1) == 1);
         else           ak = ($urandom_range(0, 7) == 0);
         step(0, rd, tgt, ak, $urandom, $urandom_range(0, 9) < 4);
      end

      // Timeout: never ack; redirect afterwards is ignored; reset recovers.
      repeat (10) idle(1);
      step(0, 1, 32'h0000_0040, 0, 32'h0, 0);
      repeat (3) idle(1);
      step(1, 0, 32'h0, 0, 32'h0, 0);
      idle(0);
      fetch(32'h0BAD_F00D, 0);

      // Misaligned redirect: faults with the check enabled, loads verbatim otherwise.
      wait_req();
      step(0, 1, 32'h0000_0102, 0, 32'h0, 0);
      fetch(32'h1234_5678, 0);
      repeat (3) idle(1);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d expected 0 pending instructions", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
